regfile_rr_encoder: RTL and testbench

- Encoder-side counterpart of the 4-to-10 write-address decoder in the TEA datapath.
- Collects one-hot/multi-hot "register updated" strobes from the 10-entry register file into a pending mask.
- Emits a stream of 4-bit register addresses (0..9), one per handshake, in round-robin order.
- The readback/sequencing logic uses the stream to fetch each updated register exactly once.

---
 rtl/tea_regfile_pkg.sv | 6 +
 rtl/rr_first_set.sv | 28 ++
 rtl/regfile_rr_encoder.sv | 61 ++++++
 tb/tb_regfile_rr_encoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tea_regfile_pkg.sv
// tea_regfile_pkg: shared register-file constants and encoder FSM state type.
package tea_regfile_pkg;
    localparam int N_REGS = 10;
    localparam int REG_AW = 4;
    typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/rr_first_set.sv
// rr_first_set: first set bit of mask searching ptr, ptr+1, ..., wrapping to ptr-1.
module rr_first_set import tea_regfile_pkg::*; #(
    parameter int N  = N_REGS,
    parameter int AW = REG_AW
) (
    input  logic [N-1:0]  mask,
    input  logic [AW-1:0] ptr,
    output logic          found,
    output logic [AW-1:0] idx
);
    logic [2*N-1:0] rot;
    logic [AW-1:0]  off;
    logic [AW:0]    sum;
    always_comb begin
        // Rotating the doubled mask puts the ptr entry at bit 0.
        rot   = {mask, mask} >> ptr;
        found = 1'b0;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = AW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (AW+1)'(N)) ? AW'(sum - (AW+1)'(N)) : sum[AW-1:0];
    end
endmodule

// File: rtl/regfile_rr_encoder.sv
// regfile_rr_encoder: collects register-update strobes and streams their addresses round-robin.
module regfile_rr_encoder import tea_regfile_pkg::*; #(
    parameter int N  = N_REGS,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  W,
    output logic [AW-1:0] RA,
    output logic          ra_valid,
    input  logic          ra_ready,
    output logic [N-1:0]  pend,
    output logic          busy
);
    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW-1:0] idx;
    logic [N-1:0]  offered;
    logic [N-1:0]  grant;
    logic [N-1:0]  mask;
    logic          found;
    logic          hs;
    assign hs      = ra_valid & ra_ready;
    assign offered = N'(1) << RA;
    assign grant   = hs ? offered : '0;
    // The bit already on offer must not be picked again as the next candidate.
    assign mask    = (state == OFFER) ? pend & ~offered : pend;
    assign busy    = |pend | ra_valid;
    rr_first_set #(.N(N), .AW(AW)) u_sel (
        .mask (mask),
        .ptr  (ptr),
        .found(found),
        .idx  (idx)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            RA       <= '0;
            ra_valid <= 1'b0;
            ptr      <= '0;
            state    <= IDLE;
        end else begin
            pend <= (pend & ~grant) | W;
            if (state == IDLE) begin
                if (found) begin
                    RA       <= idx;
                    ra_valid <= 1'b1;
                    state    <= OFFER;
                end
            end else if (hs) begin
                ptr <= (RA == AW'(N - 1)) ? '0 : RA + 1'b1;
                if (found) begin
                    RA <= idx;
                end else begin
                    ra_valid <= 1'b0;
                    state    <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_rr_encoder.sv
// tb_regfile_rr_encoder: directed vectors with hand-computed expectations for regfile_rr_encoder.
module tb_regfile_rr_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] W;
    logic [3:0] RA;
    logic       ra_valid;
    logic       ra_ready;
    logic [9:0] pend;
    logic       busy;
    int         vecs = 0;
    int         errs = 0;

    regfile_rr_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .W       (W),
        .RA      (RA),
        .ra_valid(ra_valid),
        .ra_ready(ra_ready),
        .pend    (pend),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; W = '0; ra_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pend", pend, 0);
        chk("rst_valid", ra_valid, 0);
        chk("rst_ra", RA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ptr", dut.ptr, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", ra_valid, 0);
            chk("idle_busy", busy, 0);
        end

        // single set of bit 5
        ra_ready = 1'b1; W = 10'b0000100000;
        tick();
        W = '0;
        chk("single_pend", pend, 10'h020);
        chk("single_valid_k", ra_valid, 0);
        chk("single_busy", busy, 1);
        tick();
        chk("single_ra", RA, 5);
        chk("single_valid", ra_valid, 1);
        tick();
        chk("single_pend_clr", pend, 0);
        chk("single_valid_off", ra_valid, 0);
        chk("single_ptr", dut.ptr, 6);

        // round-robin from ptr 6 over bits 1,4,6,9
        W = 10'b1001010010;
        tick();
        W = '0;
        chk("rr_pend", pend, 10'h252);
        tick(); chk("rr_ra0", RA, 6);
        tick(); chk("rr_ra1", RA, 9);
        tick(); chk("rr_ra2", RA, 1);
        tick(); chk("rr_ra3", RA, 4); chk("rr_valid3", ra_valid, 1);
        tick();
        chk("rr_done_valid", ra_valid, 0);
        chk("rr_done_pend", pend, 0);
        chk("rr_ptr", dut.ptr, 5);

        // backpressure on bits 2 and 7 from ptr 0
        rst = 1'b1; tick(); rst = 1'b0;
        ra_ready = 1'b0; W = 10'h084;
        tick();
        W = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ra_hold", RA, 2);
            chk("bp_valid_hold", ra_valid, 1);
        end
        ra_ready = 1'b1;
        tick(); chk("bp_ra_next", RA, 7); chk("bp_pend", pend, 10'h080);
        tick(); chk("bp_done", ra_valid, 0); chk("bp_ptr", dut.ptr, 8);

        // set/clear collision on bit 3 with bit 5 also pending, ptr 8
        ra_ready = 1'b0; W = 10'h028;
        tick();
        W = '0;
        tick(); chk("col_ra0", RA, 3);
        ra_ready = 1'b1; W = 10'h008;
        tick();
        W = '0;
        chk("col_pend_kept", pend, 10'h028);
        chk("col_ra1", RA, 5);
        tick(); chk("col_ra2", RA, 3); chk("col_valid2", ra_valid, 1); chk("col_pend2", pend, 10'h008);
        tick(); chk("col_done", ra_valid, 0); chk("col_pend_end", pend, 0); chk("col_ptr", dut.ptr, 4);

        // reset while offering RA=4 with all bits pending; W ignored on reset edge
        ra_ready = 1'b0; W = 10'h3FF;
        tick();
        W = '0;
        tick(); chk("mr_ra", RA, 4); chk("mr_valid", ra_valid, 1);
        rst = 1'b1; W = 10'h3FF;
        tick();
        rst = 1'b0; W = '0;
        chk("mr_pend", pend, 0);
        chk("mr_valid_off", ra_valid, 0);
        chk("mr_ptr", dut.ptr, 0);
        chk("mr_ra_rst", RA, 0);
        W = 10'h200;
        tick();
        W = '0;
        tick(); chk("mr_ra9", RA, 9); chk("mr_valid9", ra_valid, 1);
        ra_ready = 1'b1;
        tick(); chk("mr_wrap_ptr", dut.ptr, 0); chk("mr_end_valid", ra_valid, 0); chk("mr_end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
